ifmap_row_framer: RTL
=====================

// Module: ifmap_row_framer
// PURPOSE
//  Streams raw ifmap words into the per-PE IFmap buffers of the CNN array.
//  Tags every word with the 2-bit {start,end} row marker the IFmap buffers decode.
//  Distributes rows round-robin across up to CHANNELS buffers.
//  Can append a zero flush row of filter_size words per channel so the last psum drains.
// PARAMETERS
//  DATA_WIDTH        16  raw ifmap word width; out_data is DATA_WIDTH+2 bits
//  CHANNELS          4   number of downstream IFmap buffers
//  ROW_LEN_WIDTH     8   width of row_len and of the column counter
//  ROWS_WIDTH        8   width of num_rows and of the row counter
//  FILTER_SIZE_WIDTH 5   width of filter_size
// PORTS
//  clk          in   1                    rising-edge clock
//  reset        in   1                    asynchronous, active-low
//  start        in   1                    1-cycle pulse; latches configuration in IDLE
//  row_len      in   ROW_LEN_WIDTH        words per row
//  num_rows     in   ROWS_WIDTH           rows per job
//  num_channels in   $clog2(CHANNELS)+1   active channels, 1..CHANNELS
//  filter_size  in   FILTER_SIZE_WIDTH    flush row length
//  in_data      in   DATA_WIDTH           raw ifmap word
//  in_valid     in   1                    in_data valid
//  in_ready     out  1                    framer accepts in_data this cycle
//  out_data     out  DATA_WIDTH+2         {tag[1:0], word}; shared by all channels
//  out_wen      out  CHANNELS             one-hot write enable, held until accepted
//  out_ready    in   CHANNELS             per-buffer ready (IFmap_buffer_ready)
//  busy         out  1                    high from accepted start until done
//  done         out  1                    1-cycle pulse at end of job
//  cfg_error    out  1                    1-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset (async, low): state=IDLE, counters=0, ch_ptr=0, hold_valid=0.
//   All outputs 0 during reset, including in_ready.
//  FSM IDLE -> STREAM -> [FLUSH] -> DONE -> IDLE.
//   IDLE:   start latches all config inputs and enters STREAM.
//           start is rejected with cfg_error=1 for one cycle, staying in IDLE, if:
//           row_len==0, num_rows==0, filter_size==0, num_channels==0, or num_channels>CHANNELS.
//   STREAM: accepts num_rows*row_len input words.
//   FLUSH:  emits one row of filter_size zero words per active channel, channels 0..num_channels-1.
//   DONE:   done=1 for one cycle; busy=0 next cycle.
//  Tagging per row, at column position col:
//   col==0 and col==len-1 -> 2'b11; col==0 -> 2'b10; col==len-1 -> 2'b01; otherwise 2'b00.
//  Output register (single entry, hold_valid):
//   out_wen[ch_ptr] = hold_valid. out_data and out_wen stay stable until accepted.
//   Transfer occurs when out_wen[ch_ptr] & out_ready[ch_ptr] at the rising edge.
//   in_ready = (state==STREAM) & (!hold_valid | transfer).
//   Latency is 1 cycle: a word accepted at edge N drives out_data from edge N+1.
//   Throughput is 1 word/cycle while out_ready stays high.
//  Counters:
//   col wraps to 0 after row_len-1. On wrap, row increments and ch_ptr advances.
//   ch_ptr = (ch_ptr==num_channels-1) ? 0 : ch_ptr+1.
//   ch_ptr advances only on the last word's transfer, so a row never splits across channels.
//  The STREAM -> FLUSH/DONE exit happens only after the final word's transfer, not its acceptance.
//  Ignored inputs:
//   start while busy is ignored, with no error.
//   in_valid outside STREAM is ignored.
//   out_ready on non-selected channels is ignored.
//  Reset mid-job: output register is dropped; the downstream buffer sees no end tag.
//   The system must also reset the IFmap buffers.
// CONFIGURATION
//  AUTO_FLUSH_EN defined:
//   FLUSH state is present. After STREAM, emits num_channels flush rows, each tagged per the rules above.
//   ch_ptr restarts at 0 for FLUSH.
//  AUTO_FLUSH_EN undefined:
//   FLUSH state and filter_size logic are removed; STREAM goes straight to DONE.
//   filter_size==0 is then not a cfg_error condition.
// TESTING
//  T1: 1 channel, row_len=12, num_rows=1, out_ready=1, inputs 1..12.
//      -> tags 10,00x10,01. 12 writes on out_wen[0] in 12 consecutive cycles. done after the last write.
//  T2: 2 channels, row_len=3, num_rows=4.
//      -> rows 0,2 on out_wen[0]; rows 1,3 on out_wen[1]. Each row tagged 10,00,01.
//  T3: hold out_ready[0]=0 for 5 cycles mid-row.
//      -> out_data and out_wen stable. in_ready=0 after one buffered word. No word lost or duplicated.
//  T4: AUTO_FLUSH_EN, filter_size=5, 2 channels.
//      -> after data, 5 zero words tagged 10,00,00,00,01 on ch0, then the same on ch1, then done.
//  T5: start with row_len=0, then num_channels=CHANNELS+1.
//      -> cfg_error pulse each time, busy stays 0. start while busy -> ignored.
//  T6: reset low mid-row.
//      -> all outputs 0 asynchronously. After release, a new start runs a clean job with tag 10 first.

Source files
------------

// File: rtl/ifmap_row_framer_if.sv
// Handshake bundle between the ifmap row framer, its raw word source and the
// per-PE IFmap buffers. The master side is the framer itself.
interface ifmap_row_framer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH+1:0] out_data;
    logic [CHANNELS-1:0]   out_wen;
    logic [CHANNELS-1:0]   out_ready;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_wen
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_wen
    );
endinterface

// File: rtl/ifmap_row_framer.sv
// Frames raw ifmap words into {start,end}-tagged rows dealt round-robin to the IFmap buffers.
// Optional macro AUTO_FLUSH_EN adds a zero flush row of filter_size words per channel.
module ifmap_row_framer #(
    parameter int DATA_WIDTH        = 16,
    parameter int CHANNELS          = 4,
    parameter int ROW_LEN_WIDTH     = 8,
    parameter int ROWS_WIDTH        = 8,
    parameter int FILTER_SIZE_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ROW_LEN_WIDTH-1:0]       row_len,
    input  logic [ROWS_WIDTH-1:0]          num_rows,
    input  logic [$clog2(CHANNELS):0]      num_channels,
    input  logic [FILTER_SIZE_WIDTH-1:0]   filter_size,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_error,
    ifmap_row_framer_if.master             bus
);
    localparam int CW  = $clog2(CHANNELS) + 1;
    localparam int RLW = ROW_LEN_WIDTH;
    localparam int RWW = ROWS_WIDTH;
    localparam int OW  = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
`ifdef AUTO_FLUSH_EN
        ,
        FLUSH  = 2'd3
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [RLW-1:0]  col_q, col_d;
    logic [RWW-1:0]  row_q, row_d;
    logic [CW-1:0]   ch_ptr_q, ch_ptr_d;
    logic            hold_valid_q, hold_valid_d;
    logic [OW-1:0]   hold_data_q, hold_data_d;
    logic            all_in_q, all_in_d;
    logic [RLW-1:0]  row_len_q, row_len_d;
    logic [RWW-1:0]  num_rows_q, num_rows_d;
    logic [CW-1:0]   num_ch_q, num_ch_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cfg_err_q, cfg_err_d;

    logic [CHANNELS-1:0] out_wen_s;
    logic                transfer_s;
    logic                in_ready_s;
    logic                cfg_bad_s;
    logic                col_last_s;
    logic                row_last_s;

`ifdef AUTO_FLUSH_EN
    logic [FILTER_SIZE_WIDTH-1:0] fsize_q, fsize_d;
    logic                         fcol_last_s;
    logic                         frow_last_s;

    assign fcol_last_s = (col_q == (RLW'(fsize_q) - RLW'(1)));
    assign frow_last_s = (row_q == (RWW'(num_ch_q) - RWW'(1)));
    assign cfg_bad_s   = (row_len == RLW'(0)) || (num_rows == RWW'(0)) ||
                         (num_channels == CW'(0)) || (num_channels > CW'(CHANNELS)) ||
                         (filter_size == FILTER_SIZE_WIDTH'(0));
`else
    logic fsize_unused_s;

    assign fsize_unused_s = ^filter_size;
    assign cfg_bad_s      = (row_len == RLW'(0)) || (num_rows == RWW'(0)) ||
                            (num_channels == CW'(0)) || (num_channels > CW'(CHANNELS));
`endif

    assign out_wen_s  = hold_valid_q ? (CHANNELS'(1) << ch_ptr_q) : CHANNELS'(0);
    assign transfer_s = ((out_wen_s & bus.out_ready) != CHANNELS'(0));
    assign col_last_s = (col_q == (row_len_q - RLW'(1)));
    assign row_last_s = (row_q == (num_rows_q - RWW'(1)));

    assign bus.out_wen  = out_wen_s;
    assign bus.out_data = hold_data_q;
    assign bus.in_ready = in_ready_s;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_error    = cfg_err_q;

    // Next-state, counter and output-register logic for the framing FSM.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        ch_ptr_d     = ch_ptr_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        all_in_d     = all_in_q;
        row_len_d    = row_len_q;
        num_rows_d   = num_rows_q;
        num_ch_d     = num_ch_q;
        cfg_err_d    = 1'b0;
        in_ready_s   = 1'b0;
`ifdef AUTO_FLUSH_EN
        fsize_d      = fsize_q;
`endif

        // The channel pointer moves only when a row's end word leaves the register.
        if (transfer_s) begin
            hold_valid_d = 1'b0;
            if (hold_data_q[DATA_WIDTH]) begin
                ch_ptr_d = (ch_ptr_q == (num_ch_q - CW'(1))) ? CW'(0) : (ch_ptr_q + CW'(1));
            end else begin
                ch_ptr_d = ch_ptr_q;
            end
        end else begin
            hold_valid_d = hold_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (start && cfg_bad_s) begin
                    cfg_err_d = 1'b1;
                end else if (start) begin
                    row_len_d  = row_len;
                    num_rows_d = num_rows;
                    num_ch_d   = num_channels;
`ifdef AUTO_FLUSH_EN
                    fsize_d    = filter_size;
`endif
                    col_d      = RLW'(0);
                    row_d      = RWW'(0);
                    ch_ptr_d   = CW'(0);
                    all_in_d   = 1'b0;
                    state_d    = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                in_ready_s = !all_in_q && (!hold_valid_q || transfer_s);
                if (in_ready_s && bus.in_valid) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = {(col_q == RLW'(0)), col_last_s, bus.in_data};
                    if (col_last_s) begin
                        col_d = RLW'(0);
                        if (row_last_s) begin
                            all_in_d = 1'b1;
                        end else begin
                            row_d = row_q + RWW'(1);
                        end
                    end else begin
                        col_d = col_q + RLW'(1);
                    end
                end else begin
                    col_d = col_q;
                end
                if (all_in_q && transfer_s) begin
`ifdef AUTO_FLUSH_EN
                    state_d  = FLUSH;
                    col_d    = RLW'(0);
                    row_d    = RWW'(0);
                    ch_ptr_d = CW'(0);
                    all_in_d = 1'b0;
`else
                    state_d  = DONE;
`endif
                end else begin
                    state_d = STREAM;
                end
            end
`ifdef AUTO_FLUSH_EN
            FLUSH: begin
                // Flush words are generated internally; row_q counts flush rows here.
                if (!all_in_q && (!hold_valid_q || transfer_s)) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = {(col_q == RLW'(0)), fcol_last_s, DATA_WIDTH'(0)};
                    if (fcol_last_s) begin
                        col_d = RLW'(0);
                        if (frow_last_s) begin
                            all_in_d = 1'b1;
                        end else begin
                            row_d = row_q + RWW'(1);
                        end
                    end else begin
                        col_d = col_q + RLW'(1);
                    end
                end else begin
                    col_d = col_q;
                end
                if (all_in_q && transfer_s) begin
                    state_d = DONE;
                end else begin
                    state_d = FLUSH;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, counter, configuration and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            col_q        <= RLW'(0);
            row_q        <= RWW'(0);
            ch_ptr_q     <= CW'(0);
            hold_valid_q <= 1'b0;
            hold_data_q  <= OW'(0);
            all_in_q     <= 1'b0;
            row_len_q    <= RLW'(0);
            num_rows_q   <= RWW'(0);
            num_ch_q     <= CW'(0);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
`ifdef AUTO_FLUSH_EN
            fsize_q      <= FILTER_SIZE_WIDTH'(0);
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ch_ptr_q     <= ch_ptr_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            all_in_q     <= all_in_d;
            row_len_q    <= row_len_d;
            num_rows_q   <= num_rows_d;
            num_ch_q     <= num_ch_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
`ifdef AUTO_FLUSH_EN
            fsize_q      <= fsize_d;
`endif
        end
    end
endmodule
